// File: rtl/pc_gen_pkg.sv
// Shared definitions for the instruction-fetch program-counter generator.
// Holds reset/chip-enable polarities, default widths and the FSM encoding.
// Imported by pc_redirect_buf and pc_gen.
package pc_gen_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int DEFAULT_ADDR_W     = 32;
  localparam int DEFAULT_INST_BYTES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect buffer plus alignment check for the selected redirect target.
// Latency: pending/valid update one edge after load/clear; align path is combinational.
// Backpressure: none; a load overwrites any older pending target.
// Ports:
//   clk, rst          clock, async active-high reset
//   load, load_target capture a branch target that arrived during a stall
//   clear             drop the pending target (it was applied or superseded)
//   pending, valid    buffered target and its valid bit
//   target            raw redirect target chosen by the next-PC mux
//   aligned           target with the instruction-offset bits forced to zero
//   misaligned        target had nonzero offset bits
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int INST_BYTES = DEFAULT_INST_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_target,
  output logic [ADDR_W-1:0] pending,
  output logic              valid,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] aligned,
  output logic              misaligned
);

  // Mask of the byte-offset bits inside one instruction; empty when INST_BYTES=1.
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(INST_BYTES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      pending <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      pending <= load_target;
      valid   <= 1'b1;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

  assign aligned    = target & ~OFFS_MASK;
  assign misaligned = |(target & OFFS_MASK);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: stall, branch redirect, flush redirect, buffered branch.
// Latency: redirects appear on pc one edge after presentation (first unstalled edge if buffered).
// Backpressure: stall holds pc; a branch seen during stall is parked until stall drops.
// Ports:
//   clk, rst                 clock, async active-high reset
//   stall                    hold pc this cycle
//   branch_flag/target       taken branch and its destination
//   flush/flush_pc           exception redirect, overrides everything else
//   pc, ce, misalign         fetch address, imem chip enable, misaligned-redirect pulse
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = DEFAULT_ADDR_W,
  parameter int                INST_BYTES = DEFAULT_INST_BYTES,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              misalign
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] pc_next;
  logic              misalign_next;

  logic              buf_load, buf_clear;
  logic [ADDR_W-1:0] buf_pending, raw_target, aligned_target;
  logic              buf_valid, target_misaligned;
  logic              redirect;

  pc_redirect_buf #(
    .ADDR_W     (ADDR_W),
    .INST_BYTES (INST_BYTES)
  ) u_redirect_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (buf_load),
    .clear       (buf_clear),
    .load_target (branch_target),
    .pending     (buf_pending),
    .valid       (buf_valid),
    .target      (raw_target),
    .aligned     (aligned_target),
    .misaligned  (target_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= pc_next;
      misalign <= misalign_next;
    end
  end

  // Next-state and next-PC selection. In IDLE the only action is entering RUN
  // with pc still at RESET_PC, so the first fetch is RESET_PC itself.
  always_comb begin
    next_state    = state;
    pc_next       = pc;
    misalign_next = 1'b0;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    redirect      = 1'b0;
    raw_target    = buf_pending;

    if (state == IDLE) begin
      next_state = RUN;
    end else begin
      if (flush) begin
        // A branch arriving alongside a flush is dropped, not buffered.
        raw_target = flush_pc;
        redirect   = 1'b1;
        buf_clear  = 1'b1;
      end else if (stall) begin
        buf_load = branch_flag;
      end else if (branch_flag) begin
        // The live branch is younger than anything pending, so it wins.
        raw_target = branch_target;
        redirect   = 1'b1;
        buf_clear  = 1'b1;
      end else if (buf_valid) begin
        raw_target = buf_pending;
        redirect   = 1'b1;
        buf_clear  = 1'b1;
      end else begin
        pc_next = pc + ADDR_W'(INST_BYTES);
      end

      if (redirect) begin
        pc_next       = aligned_target;
        misalign_next = target_misaligned;
      end
    end
  end

  assign ce = (state == RUN) ? ChipEnable : ChipDisable;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam int IB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, branch_flag = 1'b0, flush = 1'b0;
  logic [31:0] branch_target = '0, flush_pc = '0;
  logic [31:0] pc;
  logic        ce, misalign;

  logic        branch8 = 1'b0;
  logic [7:0]  target8 = '0;
  logic [7:0]  pc8;
  logic        ce8, misalign8;

  int checks = 0;
  int errors = 0;

  // Reference model state: architectural view only.
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pv;
  logic [31:0] m_pend;
  bit          m_mis;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(32), .INST_BYTES(IB), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .pc            (pc),
    .ce            (ce),
    .misalign      (misalign)
  );

  pc_gen #(.ADDR_W(8), .INST_BYTES(IB), .RESET_PC(8'h0)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .stall         (1'b0),
    .branch_flag   (branch8),
    .branch_target (target8),
    .flush         (1'b0),
    .flush_pc      (8'h0),
    .pc            (pc8),
    .ce            (ce8),
    .misalign      (misalign8)
  );

  function automatic logic [31:0] al(input logic [31:0] x);
    return x - (x % IB);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = 32'h0; m_pv = 0; m_pend = 32'h0; m_mis = 0;
  endtask

  task automatic model_edge(input bit s, input bit b, input logic [31:0] bt,
                            input bit f, input logic [31:0] fp);
    m_mis = 0;
    if (!m_run) begin
      m_run = 1;
    end else if (f) begin
      m_pc = al(fp); m_mis = (fp % IB) != 0; m_pv = 0;
    end else if (s) begin
      if (b) begin m_pend = bt; m_pv = 1; end
    end else if (b) begin
      m_pc = al(bt); m_mis = (bt % IB) != 0; m_pv = 0;
    end else if (m_pv) begin
      m_pc = al(m_pend); m_mis = (m_pend % IB) != 0; m_pv = 0;
    end else begin
      m_pc = m_pc + IB;
    end
  endtask

  task automatic check_main(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".ce"}, {31'b0, ce}, {31'b0, m_run});
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, check at the next negedge.
  task automatic step(input bit s, input bit b, input logic [31:0] bt,
                      input bit f, input logic [31:0] fp, input string tag);
    stall = s; branch_flag = b; branch_target = bt; flush = f; flush_pc = fp;
    @(posedge clk);
    model_edge(s, b, bt, f, fp);
    @(negedge clk);
    check_main(tag);
  endtask

  initial begin
    model_reset();
    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_main("reset");
    end
    rst = 1'b0;
    step(0, 0, 0, 0, 0, "release");        // ce=1, pc=0
    step(0, 0, 0, 0, 0, "seq4");
    step(0, 0, 0, 0, 0, "seq8");
    step(0, 0, 0, 0, 0, "seqC");
    step(0, 0, 0, 0, 0, "seq10");
    chk("at_0x10", pc, 32'h10);

    // Branch during stall is buffered and applied when stall drops.
    step(1, 1, 32'h100, 0, 0, "stall1");
    step(1, 0, 0, 0, 0, "stall2");
    chk("stall_hold", pc, 32'h10);
    step(0, 0, 0, 0, 0, "pend_apply");
    chk("pend_0x100", pc, 32'h100);
    step(0, 0, 0, 0, 0, "after_pend");

    // Flush beats stall and branch; the branch is not buffered.
    step(1, 1, 32'h200, 1, 32'h80, "flush");
    chk("flush_0x80", pc, 32'h80);
    step(0, 0, 0, 0, 0, "after_flush");
    chk("flush_no_pend", pc, 32'h84);

    // Misaligned redirect: aligned target and a one-cycle pulse.
    step(0, 1, 32'h103, 0, 0, "mis_br");
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
    step(0, 0, 0, 0, 0, "mis_after");

    // Misaligned branch while stalled: no pulse until it is applied.
    step(1, 1, 32'h203, 0, 0, "mis_buf");
    step(0, 0, 0, 0, 0, "mis_buf_apply");

    // Async reset mid-run with a pending branch.
    step(0, 1, 32'h40, 0, 0, "to_0x40");
    step(1, 1, 32'h300, 0, 0, "pend_0x300");
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_main("async_rst");
    @(negedge clk);
    check_main("async_rst_hold");
    rst = 1'b0;
    step(0, 0, 0, 0, 0, "rerelease");
    step(0, 0, 0, 0, 0, "restart4");
    step(0, 0, 0, 0, 0, "restart8");
    chk("no_stale_pend", pc, 32'h8);

    // 8-bit instance: wrap-around from 0xFC to 0x00.
    branch8 = 1'b1; target8 = 8'hF8;
    step(0, 0, 0, 0, 0, "w0");
    branch8 = 1'b0;
    chk("w8.pc_F8", {24'b0, pc8}, 32'hF8);
    step(0, 0, 0, 0, 0, "w1");
    chk("w8.pc_FC", {24'b0, pc8}, 32'hFC);
    step(0, 0, 0, 0, 0, "w2");
    chk("w8.pc_00", {24'b0, pc8}, 32'h00);
    chk("w8.ce", {31'b0, ce8}, 32'h1);
    chk("w8.misalign", {31'b0, misalign8}, 32'h0);
    step(0, 0, 0, 0, 0, "w3");
    chk("w8.pc_04", {24'b0, pc8}, 32'h04);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit s, b, f;
      logic [31:0] bt, fp;
      s  = ($urandom_range(0, 99) < 30);
      b  = ($urandom_range(0, 99) < 25);
      f  = ($urandom_range(0, 99) < 8);
      bt = $urandom();
      fp = $urandom();
      if (n == 200) begin
        // Drive near the top of the 32-bit space to exercise wrap.
        step(0, 1, 32'hFFFF_FFF4, 0, 0, "rnd_hi");
      end else begin
        step(s, b, bt, f, fp, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
